// File: rtl/alu_handshake.sv
// Parametrised ALU with valid/ready handshakes on both sides, registered ZERO/CARRY flags
// and an optional iterative shift-add multiplier.
module alu_handshake #(
   parameter int WIDTH    = 8,
   parameter bit MUL_ITER = 1'b1
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] IN_A,
   input  logic [WIDTH-1:0] IN_B,
   input  logic [WIDTH-1:0] IMM,
   input  logic [7:0]       INSTRUCT,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] OUT_RESULT,
   output logic             OUT_ZERO,
   output logic             OUT_CARRY
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
   localparam logic [3:0]       SEL_IMM_B = 4'hD;
   localparam logic [3:0]       SEL_IMM_A = 4'hE;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DONE
   } state_e;

   typedef enum logic [3:0] {
      OP_ADD   = 4'h0,
      OP_SUB   = 4'h1,
      OP_MUL   = 4'h2,
      OP_SHL_A = 4'h3,
      OP_SHR_A = 4'h4,
      OP_INC_A = 4'h5,
      OP_INC_B = 4'h6,
      OP_DEC_A = 4'h7,
      OP_DEC_B = 4'h8,
      OP_EQ    = 4'h9,
      OP_GT    = 4'hA,
      OP_LT    = 4'hB,
      OP_AND   = 4'hC,
      OP_OR    = 4'hD,
      OP_SHL_B = 4'hE,
      OP_SHR_B = 4'hF
   } op_e;

   state_e           state;
   state_e           state_nxt;
   op_e              op;
   logic [3:0]       sel;

   logic [WIDTH-1:0] arg_a;
   logic [WIDTH-1:0] arg_b;
   logic [WIDTH-1:0] shamt_a;
   logic [WIDTH-1:0] shamt_b;
   logic [WIDTH:0]   sum_ext;
   logic [WIDTH-1:0] alu_res;
   logic             alu_carry;

   logic [CNT_W-1:0] mul_cnt;
   logic [WIDTH-1:0] mul_acc;
   logic [WIDTH-1:0] mul_mcand;
   logic [WIDTH-1:0] mul_mplier;
   logic [WIDTH-1:0] mul_acc_step;

   logic             load_result;
   logic             mul_start;
   logic             mul_step;
   logic [WIDTH-1:0] res_nxt;
   logic             carry_nxt;

   assign op  = op_e'(INSTRUCT[7:4]);
   assign sel = INSTRUCT[3:0];

   // Operand select; shift amounts come from the immediate-substituted operand, else 1.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
      arg_a = IN_A;
      arg_b = IN_B;
      if (sel == SEL_IMM_B) begin
         arg_b = IMM;
      end else if (sel == SEL_IMM_A) begin
         arg_a = IMM;
      end
      shamt_a = (sel == SEL_IMM_B) ? arg_b : ONE;
      shamt_b = (sel == SEL_IMM_A) ? arg_a : ONE;
   end

   assign sum_ext = {1'b0, arg_a} + {1'b0, arg_b};

   // Shifts by the full operand value; SV shift semantics already yield 0 for amounts >= WIDTH.
   always_comb begin
      alu_res   = '0;
      alu_carry = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res   = sum_ext[WIDTH-1:0];
            alu_carry = sum_ext[WIDTH];
         end
         OP_SUB: begin
            alu_res   = arg_a - arg_b;
            alu_carry = (arg_a < arg_b);
         end
         OP_MUL:   alu_res = arg_a * arg_b;
         OP_SHL_A: alu_res = arg_a << shamt_a;
         OP_SHR_A: alu_res = arg_a >> shamt_a;
         OP_INC_A: alu_res = IN_A + ONE;
         OP_INC_B: alu_res = IN_B + ONE;
         OP_DEC_A: alu_res = IN_A - ONE;
         OP_DEC_B: alu_res = IN_B - ONE;
         OP_EQ:    alu_res = {{(WIDTH-1){1'b0}}, (IN_A == IN_B)};
         OP_GT:    alu_res = {{(WIDTH-1){1'b0}}, (IN_A >  IN_B)};
         OP_LT:    alu_res = {{(WIDTH-1){1'b0}}, (IN_A <  IN_B)};
         OP_AND:   alu_res = arg_a & arg_b;
         OP_OR:    alu_res = arg_a | arg_b;
         OP_SHL_B: alu_res = arg_b << shamt_b;
         OP_SHR_B: alu_res = arg_b >> shamt_b;
      endcase
   end

   // One LSB-first shift-add step: multiplicand doubles while the multiplier is consumed.
   assign mul_acc_step = mul_mplier[0] ? (mul_acc + mul_mcand) : mul_acc;

   always_comb begin
      state_nxt   = state;
      load_result = 1'b0;
      mul_start   = 1'b0;
      mul_step    = 1'b0;
      res_nxt     = alu_res;
      carry_nxt   = alu_carry;
      case (state)
         S_IDLE: begin
            if (IN_VALID) begin
               if (MUL_ITER && (op == OP_MUL)) begin
                  mul_start = 1'b1;
                  state_nxt = S_MUL;
               end else begin
                  load_result = 1'b1;
                  state_nxt   = S_DONE;
               end
            end
         end
         S_MUL: begin
            mul_step = 1'b1;
            if (mul_cnt == CNT_ONE) begin
               load_result = 1'b1;
               res_nxt     = mul_acc_step;
               carry_nxt   = 1'b0;
               state_nxt   = S_DONE;
            end
         end
         S_DONE: begin
            if (OUT_READY) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
      if (!RESET_N) begin
         state      <= S_IDLE;
         OUT_RESULT <= '0;
         OUT_ZERO   <= 1'b0;
         OUT_CARRY  <= 1'b0;
         mul_cnt    <= '0;
         mul_acc    <= '0;
         mul_mcand  <= '0;
         mul_mplier <= '0;
      end else begin
         state <= state_nxt;
         if (load_result) begin
            OUT_RESULT <= res_nxt;
            OUT_ZERO   <= (res_nxt == '0);
            OUT_CARRY  <= carry_nxt;
         end
         if (mul_start) begin
            mul_cnt    <= CNT_INIT;
            mul_acc    <= '0;
            mul_mcand  <= arg_a;
            mul_mplier <= arg_b;
         end else if (mul_step) begin
            mul_cnt    <= mul_cnt - CNT_ONE;
            mul_acc    <= mul_acc_step;
            mul_mcand  <= {mul_mcand[WIDTH-2:0], 1'b0};
            mul_mplier <= {1'b0, mul_mplier[WIDTH-1:1]};
         end
      end
   end

   assign IN_READY  = (state == S_IDLE);
   assign OUT_VALID = (state == S_DONE);

endmodule

// File: tb/tb_alu_handshake.sv
// Directed and randomized checks of alu_handshake (WIDTH=8, iterative multiply) against an
// arithmetic reference model.
module tb_alu_handshake;

   localparam int W   = 8;
   localparam int MOD = 1 << W;

   logic         CLK = 1'b0;
   logic         RESET_N;
   logic         IN_VALID;
   logic         IN_READY;
   logic [W-1:0] IN_A;
   logic [W-1:0] IN_B;
   logic [W-1:0] IMM;
   logic [7:0]   INSTRUCT;
   logic         OUT_VALID;
   logic         OUT_READY;
   logic [W-1:0] OUT_RESULT;
   logic         OUT_ZERO;
   logic         OUT_CARRY;

   int n_tests = 0;
   int n_fail  = 0;

   alu_handshake #(.WIDTH(W), .MUL_ITER(1'b1)) dut (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .IN_VALID   (IN_VALID),
      .IN_READY   (IN_READY),
      .IN_A       (IN_A),
      .IN_B       (IN_B),
      .IMM        (IMM),
      .INSTRUCT   (INSTRUCT),
      .OUT_VALID  (OUT_VALID),
      .OUT_READY  (OUT_READY),
      .OUT_RESULT (OUT_RESULT),
      .OUT_ZERO   (OUT_ZERO),
      .OUT_CARRY  (OUT_CARRY)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model straight from the opcode table, in integer arithmetic.
   function automatic void model(input int instr, input int a, input int b, input int imm,
                                 output int res, output int carry);
      int sel, op, ea, eb, s;
      sel   = instr % 16;
      op    = instr / 16;
      ea    = (sel == 14) ? imm : a;
      eb    = (sel == 13) ? imm : b;
      carry = 0;
      res   = 0;
      case (op)
         0:  begin res = (ea + eb) % MOD; carry = (ea + eb >= MOD) ? 1 : 0; end
         1:  begin res = (ea - eb + MOD) % MOD; carry = (ea < eb) ? 1 : 0; end
         2:  res = (ea * eb) % MOD;
         3:  begin s = (sel == 13) ? eb : 1; res = (s >= W) ? 0 : (ea * (1 << s)) % MOD; end
         4:  begin s = (sel == 13) ? eb : 1; res = (s >= W) ? 0 : ea / (1 << s); end
         5:  res = (a + 1) % MOD;
         6:  res = (b + 1) % MOD;
         7:  res = (a + MOD - 1) % MOD;
         8:  res = (b + MOD - 1) % MOD;
         9:  res = (a == b) ? 1 : 0;
         10: res = (a > b) ? 1 : 0;
         11: res = (a < b) ? 1 : 0;
         12: res = ea & eb;
         13: res = ea | eb;
         14: begin s = (sel == 14) ? ea : 1; res = (s >= W) ? 0 : (eb * (1 << s)) % MOD; end
         15: begin s = (sel == 14) ? ea : 1; res = (s >= W) ? 0 : eb / (1 << s); end
         default: res = 0;
      endcase
   endfunction

   // One transaction: present, accept, measure latency, check, optionally stall in DONE, release.
   task automatic run_op(input logic [7:0] instr, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] imm, input int hold, input bit poke);
      int exp_res, exp_carry, exp_lat, lat;
      model(instr, a, b, imm, exp_res, exp_carry);
      exp_lat = (instr[7:4] == 4'h2) ? W + 1 : 1;
      @(negedge CLK);
      check("ready_idle", IN_READY, 1);
      IN_VALID  = 1'b1;
      INSTRUCT  = instr;
      IN_A      = a;
      IN_B      = b;
      IMM       = imm;
      OUT_READY = 1'b0;
      @(posedge CLK);
      #1;
      IN_VALID = 1'b0;
      IN_A     = W'($urandom);
      IN_B     = W'($urandom);
      IMM      = W'($urandom);
      INSTRUCT = 8'($urandom);
      lat = 1;
      while (!OUT_VALID && lat < 40) begin
         check("ready_busy", IN_READY, 0);
         @(posedge CLK);
         #1;
         lat++;
      end
      check("latency", lat, exp_lat);
      check("result", OUT_RESULT, exp_res);
      check("zero", OUT_ZERO, (exp_res == 0) ? 1 : 0);
      check("carry", OUT_CARRY, exp_carry);
      check("ready_done", IN_READY, 0);
      for (int i = 0; i < hold; i++) begin
         @(negedge CLK);
         if (poke) begin
            IN_VALID = 1'b1;
            IN_A     = W'($urandom);
            IN_B     = W'($urandom);
            INSTRUCT = 8'($urandom);
         end
         @(posedge CLK);
         #1;
         check("hold_valid", OUT_VALID, 1);
         check("hold_result", OUT_RESULT, exp_res);
         check("hold_zero", OUT_ZERO, (exp_res == 0) ? 1 : 0);
         check("hold_carry", OUT_CARRY, exp_carry);
         check("hold_ready", IN_READY, 0);
      end
      @(negedge CLK);
      IN_VALID  = 1'b0;
      OUT_READY = 1'b1;
      @(posedge CLK);
      #1;
      OUT_READY = 1'b0;
      check("release_valid", OUT_VALID, 0);
      check("release_ready", IN_READY, 1);
      check("release_result", OUT_RESULT, exp_res);
   endtask

   initial begin
      logic [3:0] op4;
      logic [3:0] sel4;
      logic [7:0] ra, rb, ri;

      RESET_N   = 1'b0;
      IN_VALID  = 1'b0;
      IN_A      = '0;
      IN_B      = '0;
      IMM       = '0;
      INSTRUCT  = '0;
      OUT_READY = 1'b0;
      #1;
      check("rst_valid", OUT_VALID, 0);
      check("rst_result", OUT_RESULT, 0);
      check("rst_zero", OUT_ZERO, 0);
      check("rst_carry", OUT_CARRY, 0);
      check("rst_ready", IN_READY, 1);
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      RESET_N = 1'b1;

      // Add with carry-out.
      run_op(8'h00, 8'hF0, 8'h20, 8'h00, 0, 1'b0);
      check("t1_result", OUT_RESULT, 8'h10);
      check("t1_carry", OUT_CARRY, 1);
      check("t1_zero", OUT_ZERO, 0);

      // Subtract with borrow, then subtract to zero.
      run_op(8'h10, 8'h05, 8'h07, 8'h00, 0, 1'b0);
      check("t3a_result", OUT_RESULT, 8'hFE);
      check("t3a_carry", OUT_CARRY, 1);
      run_op(8'h10, 8'h07, 8'h07, 8'h00, 0, 1'b0);
      check("t3b_zero", OUT_ZERO, 1);
      check("t3b_carry", OUT_CARRY, 0);

      // Immediate shift amounts, including one past the width.
      run_op(8'h3D, 8'h11, 8'h55, 8'h03, 0, 1'b0);
      check("t4a_result", OUT_RESULT, 8'h88);
      run_op(8'h3D, 8'h11, 8'h55, 8'h09, 0, 1'b0);
      check("t4b_result", OUT_RESULT, 8'h00);
      run_op(8'h4D, 8'h80, 8'h55, 8'h07, 0, 1'b0);
      check("t4c_result", OUT_RESULT, 8'h01);

      // Iterative multiply.
      run_op(8'h20, 8'h0D, 8'h0B, 8'h00, 0, 1'b0);
      check("t2_result", OUT_RESULT, 8'h8F);

      // Consumer stall with a new request presented while DONE.
      run_op(8'h00, 8'hF0, 8'h35, 8'h00, 5, 1'b1);
      check("t5_result", OUT_RESULT, 8'h25);

      // Reset in the middle of a multiply.
      @(negedge CLK);
      IN_VALID = 1'b1;
      INSTRUCT = 8'h20;
      IN_A     = 8'h0D;
      IN_B     = 8'h0B;
      @(posedge CLK);
      #1;
      IN_VALID = 1'b0;
      repeat (4) @(posedge CLK);
      #1;
      check("t6_busy_ready", IN_READY, 0);
      check("t6_busy_valid", OUT_VALID, 0);
      RESET_N = 1'b0;
      #1;
      check("t6_rst_valid", OUT_VALID, 0);
      check("t6_rst_result", OUT_RESULT, 0);
      check("t6_rst_carry", OUT_CARRY, 0);
      check("t6_rst_ready", IN_READY, 1);
      @(negedge CLK);
      RESET_N = 1'b1;
      run_op(8'h50, 8'hFF, 8'h12, 8'h00, 0, 1'b0);
      check("t6_inc_result", OUT_RESULT, 8'h00);
      check("t6_inc_zero", OUT_ZERO, 1);

      // Randomized sweep over all opcodes and selector forms.
      for (int i = 0; i < 80; i++) begin
         op4 = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 2))
            0:       sel4 = 4'hD;
            1:       sel4 = 4'hE;
            default: sel4 = 4'($urandom);
         endcase
         ra = 8'($urandom);
         rb = ($urandom_range(0, 4) == 0) ? ra : 8'($urandom);
         ri = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom);
         if (sel4 == 4'hE && $urandom_range(0, 1) == 1) begin
            ri = 8'($urandom_range(0, 10));
         end
         run_op({op4, sel4}, ra, rb, ri, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
